// File: rtl/shift_sequencer.sv
// Multi-pass controller that extends the 8-bit barrel shifter to shift amounts of 0..2^AMT_W-1.
// It feeds the shifter at most 7 bits per pass and loops bs_out back as the next pass's input.
module shift_sequencer #(
    parameter int unsigned AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       data_in,
    input  logic [AMT_W-1:0] amount,
    input  logic             dir,
    input  logic             sh_roBar,
    output logic             busy,
    output logic             done,
    output logic [7:0]       result,
    output logic             c,
    output logic             z,
    output logic [7:0]       bs_data,
    output logic [2:0]       bs_bitcount,
    output logic             bs_dir,
    output logic             bs_sh_roBar,
    input  logic [7:0]       bs_out,
    input  logic             bs_c,
    input  logic             bs_z
);

    localparam int unsigned MAX_CHUNK = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       work;
    logic [AMT_W-1:0] rem;
    logic             dir_q;
    logic             mode_q;

    logic [2:0]       chunk;
    logic [AMT_W-1:0] rem_next;

    // Largest chunk the shifter can take this pass, and what remains after it.
    always_comb begin
        chunk    = (rem > AMT_W'(MAX_CHUNK)) ? 3'(MAX_CHUNK) : rem[2:0];
        rem_next = rem - AMT_W'(chunk);
    end

    // The shifter is driven straight from the working registers.
    always_comb begin
        bs_data     = work;
        bs_bitcount = (state == RUN) ? chunk : 3'd0;
        bs_dir      = dir_q;
        bs_sh_roBar = mode_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            work   <= 8'h00;
            rem    <= '0;
            dir_q  <= 1'b0;
            mode_q <= 1'b0;
            result <= 8'h00;
            c      <= 1'b0;
            z      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (amount != '0) begin
                            work   <= data_in;
                            rem    <= amount;
                            dir_q  <= dir;
                            mode_q <= sh_roBar;
                            state  <= RUN;
                        end else begin
                            // Zero amount bypasses the shifter entirely.
                            result <= data_in;
                            c      <= 1'b0;
                            z      <= (data_in == 8'h00);
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                RUN: begin
                    work <= bs_out;
                    c    <= bs_c;
                    z    <= bs_z;
                    rem  <= rem_next;
                    if (rem_next == '0) begin
                        result <= bs_out;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
